fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side controller for the team's 8-bit synchronous FIFO. It issues `rd` strobes to the FIFO whenever data is available and downstream space exists, and absorbs the FIFO's one-cycle registered read latency. It presents the bytes on a valid/ready stream through a 2-entry output buffer. It sits between the FIFO's read port and any streaming consumer, and counts delivered bytes.

## Interface
- `WIDTH`, 8, data width; must match the FIFO.
- `CNT_W`, 16, width of the delivered-byte counter.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  drain enable; when low, no new `fifo_rd` is issued.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_wr`  in  1  copy of the FIFO's `wr` input; FIFO write has priority, so a read in the same cycle is ignored.
- `fifo_dout`  in  WIDTH  FIFO `data_out`, registered, valid the cycle after an accepted read.
- `fifo_rd`  out  1  read strobe to the FIFO.
- `out_valid`  out  1  stream data valid.
- `out_data`  out  WIDTH  stream data, oldest buffered byte.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `out_count`  out  CNT_W  bytes delivered since reset.

## Operation
- **Reset values:** `fifo_rd`=0, `out_valid`=0, `out_data`=0, `out_count`=0, buffer count=0, `pending`=0.
- **Pop:** `pop_out` = `out_valid` && `out_ready`.
- **Read issue:** `fifo_rd` = `en` && !`fifo_empty` && (count + `pending` − `pop_out`) < 2. This is combinational from `out_ready`, `en` and `fifo_empty`.
- **Accepted read:** `acc` = `fifo_rd` && !`fifo_wr`. `pending` is registered from `acc`.
  - When `fifo_wr` blocks a read, the strobe is wasted, nothing is captured, and the read is retried next cycle if the condition still holds.
- **Capture:** when `pending`=1, `fifo_dout` is written into the buffer tail.
  - Capture and pop in the same cycle: count unchanged and order preserved.
  - Capture into an empty buffer with no pop: the byte becomes `out_data` next cycle.
- **Buffer:** 2 entries, FIFO order. `out_valid` = count≠0. `out_data` is held stable while `out_valid` && !`out_ready`.
- **Counter:** `out_count` increments by 1 on each `pop_out` and wraps from 2^CNT_W−1 to 0.
- **`en` falling:** no new reads are issued; an in-flight byte (`pending`=1) is still captured; the buffer keeps draining.
- **Overflow guard:** the credit rule guarantees count + `pending` ≤ 2. A capture into a full buffer must never occur; add an assertion for it.

## Timing
- **Latency:** accepted `fifo_rd` in cycle N; `fifo_dout` captured at the end of N+1; `out_valid`=1 in N+2 at the earliest. First byte reaches the stream 2 cycles after the strobe.
- **Throughput:** 1 byte/cycle sustained when FIFO is non-empty, `out_ready`=1 and `fifo_wr`=0. Steady state is count=1, `pending`=1.
- **Backpressure:** with `out_ready`=0, at most 2 bytes are held (buffered plus in flight), and reads then stop.
- **Reset mid-operation:** all state clears immediately (asynchronous). A byte in flight or buffered is discarded and not counted.

## Structure
- **Shared package `fifo_pkg`:**
  - `FIFO_WIDTH` = 8.
  - `typedef logic [FIFO_WIDTH-1:0] fifo_data_t`.
  - `SKID_DEPTH` = 2.
- **Sub-module `skid_buf2`:** 2-entry register FIFO with push/pop, count, head output, and the same `clock`/`rst`.
- **Top level `fifo_drain`:** read-issue logic, `pending` flag and counter.

## Test plan
- **Basic burst:** FIFO preloaded with 0x11,0x22,0x33; `en`=1, `out_ready`=1 → `fifo_rd` high for 3 cycles from cycle 0; `out_data` 0x11,0x22,0x33 in cycles 2–4; `out_count`=3; `fifo_rd` drops when `fifo_empty`=1.
- **Write collision:** `fifo_wr`=1 during the first `fifo_rd` cycle → no capture from that cycle; the read is retried; output order and values are unchanged and nothing is duplicated.
- **Backpressure:** 5 bytes queued, `out_ready`=0 → exactly 2 accepted reads, then `fifo_rd`=0, `out_data` is held at byte 0. Release `out_ready` → all 5 delivered in order, one per cycle.
- **Disable in flight:** drop `en` the cycle after an accepted read → that byte is still delivered and no further `fifo_rd` is issued.
- **Async reset:** assert `rst` mid-clock-period with 2 bytes buffered → `out_valid`, `fifo_rd` and `out_count` go to 0 immediately without waiting for a clock edge.
- **Counter wrap:** `CNT_W`=4, 17 bytes delivered → `out_count` reads 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit synchronous FIFO and its read-side logic.
//   FIFO_WIDTH  : data width of the FIFO and of the drained stream
//   fifo_data_t : one FIFO data word
//   SKID_DEPTH  : number of entries in the output skid buffer
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;

    typedef logic [FIFO_WIDTH-1:0] fifo_data_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO that holds bytes between the FIFO read port
// and the output stream.
//   clock : rising-edge clock
//   rst   : asynchronous active-high reset
//   push  : write din into the tail
//   pop   : remove the head entry
//   din   : data to push
//   head  : oldest stored entry
//   count : number of stored entries (0..2)
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The read credit in the drain controller keeps buffered plus in-flight
    // bytes at or below two, so a push can never land on a full buffer.
    a_no_push_when_full : assert property (
        @(posedge clock) disable iff (rst) !(push && count == 2'd2)
    );

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the 8-bit synchronous FIFO. Issues read strobes
// when data is available and the output buffer has credit, captures the
// registered FIFO output one cycle later, and presents bytes on a
// valid/ready stream while counting delivered bytes.
//   clock      : rising-edge clock
//   rst        : asynchronous active-high reset
//   en         : drain enable; low stops new reads
//   fifo_empty : FIFO empty flag
//   fifo_wr    : FIFO write strobe; a write blocks a same-cycle read
//   fifo_dout  : FIFO registered read data
//   fifo_rd    : read strobe to the FIFO
//   out_valid  : stream valid
//   out_data   : stream data (oldest buffered byte)
//   out_ready  : stream ready
//   out_count  : bytes delivered since reset (wraps)
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic             fifo_wr,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    logic       pending;
    logic       pop_out;
    logic       acc;
    logic [1:0] buf_count;
    logic [2:0] occupancy;
    logic [2:0] credit_limit;

    skid_buf2 #(.WIDTH(WIDTH)) u_skid (
        .clock (clock),
        .rst   (rst),
        .push  (pending),
        .pop   (pop_out),
        .din   (fifo_dout),
        .head  (out_data),
        .count (buf_count)
    );

    assign out_valid = (buf_count != 2'd0);
    assign pop_out   = out_valid && out_ready;

    // count + pending - pop < 2, rearranged to avoid an unsigned underflow.
    assign occupancy    = {1'b0, buf_count} + {2'b00, pending};
    assign credit_limit = 3'd2 + {2'b00, pop_out};

    // Gated by rst so the strobe drops immediately on an asynchronous reset.
    assign fifo_rd = !rst && en && !fifo_empty && (occupancy < credit_limit);

    // A simultaneous FIFO write wins, so the strobe is wasted and retried.
    assign acc = fifo_rd && !fifo_wr;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            out_count <= '0;
        end else begin
            pending <= acc;
            if (pop_out) begin
                out_count <= out_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;

    logic        clock;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic        fifo_wr;
    logic [7:0]  fifo_dout;
    logic        fifo_rd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] out_count;

    logic        fifo_rd4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  out_count4;

    logic [7:0]  wr_data;
    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];

    int checks;
    int failures;

    fifo_drain dut (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_count  (out_count)
    );

    fifo_drain #(.CNT_W(4)) dut4 (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready),
        .out_count  (out_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FIFO model: write has priority over a same-cycle read; every written
    // byte is pushed to the scoreboard in order.
    initial begin
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
    end
    always @(posedge clock) begin
        if (fifo_rd && !fifo_wr && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
        end
        if (fifo_wr) begin
            fq.push_back(wr_data);
            exp_q.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Scoreboard monitor on stream handshakes.
    always @(negedge clock) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stream_unexpected got=%02h expected=none", out_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL stream_data got=%02h expected=%02h", out_data, e);
                end
            end
        end
    end

    task automatic write_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_wr = 1'b1;
            wr_data = base + 8'(i);
            @(posedge clock); #1;
        end
        fifo_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        automatic bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !out_valid && fifo_empty) done = 1'b1;
        end
        @(posedge clock); #1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain_timeout left=%0d expected=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; fifo_wr = 1'b0; wr_data = 8'h00; out_ready = 1'b0;
        #1;
        checks += 4;
        if (fifo_rd !== 1'b0)      begin failures++; $display("FAIL reset_fifo_rd got=%b expected=0", fifo_rd); end
        if (out_valid !== 1'b0)    begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
        if (out_data !== 8'h00)    begin failures++; $display("FAIL reset_out_data got=%02h expected=00", out_data); end
        if (out_count !== 16'd0)   begin failures++; $display("FAIL reset_out_count got=%0d expected=0", out_count); end
        @(posedge clock); @(posedge clock); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_burst;
        logic [7:0] bytes_exp [3];
        bytes_exp[0] = 8'h11; bytes_exp[1] = 8'h22; bytes_exp[2] = 8'h33;
        write_bytes(8'h11, 1);
        write_bytes(8'h22, 1);
        write_bytes(8'h33, 1);
        en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (fifo_rd !== (c < 3)) begin
                failures++; $display("FAIL burst_fifo_rd cycle=%0d got=%b expected=%b", c, fifo_rd, (c < 3));
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== bytes_exp[c-2]) begin
                    failures++;
                    $display("FAIL burst_out cycle=%0d got=%b/%02h expected=1/%02h", c, out_valid, out_data, bytes_exp[c-2]);
                end
            end
            @(posedge clock); #1;
        end
        checks++;
        if (out_count !== 16'd3) begin failures++; $display("FAIL burst_count got=%0d expected=3", out_count); end
        drain("burst");
        en = 1'b0;
    endtask

    task automatic test_write_collision;
        automatic logic [15:0] base = out_count;
        write_bytes(8'hA1, 3);
        en = 1'b1; out_ready = 1'b1;
        fifo_wr = 1'b1; wr_data = 8'hA4;
        @(negedge clock);
        checks++;
        if (fifo_rd !== 1'b1) begin failures++; $display("FAIL collide_strobe got=%b expected=1", fifo_rd); end
        @(posedge clock); #1;
        fifo_wr = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL collide_no_capture cycle=%0d got=%b expected=0", c, out_valid); end
            @(posedge clock); #1;
        end
        drain("collide");
        checks++;
        if (out_count !== base + 16'd4) begin
            failures++; $display("FAIL collide_count got=%0d expected=%0d", out_count, base + 16'd4);
        end
        en = 1'b0;
    endtask

    task automatic test_backpressure;
        automatic int accepted = 0;
        automatic int run = 0;
        out_ready = 1'b0;
        write_bytes(8'hB0, 5);
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (fifo_rd && !fifo_wr) accepted++;
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks += 3;
        if (accepted !== 2) begin failures++; $display("FAIL bp_accepted got=%0d expected=2", accepted); end
        if (fifo_rd !== 1'b0) begin failures++; $display("FAIL bp_rd_stopped got=%b expected=0", fifo_rd); end
        if (out_valid !== 1'b1 || out_data !== 8'hB0) begin
            failures++; $display("FAIL bp_hold got=%b/%02h expected=1/b0", out_valid, out_data);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (out_valid) run++;
            @(posedge clock); #1;
        end
        checks++;
        if (run !== 5) begin failures++; $display("FAIL bp_throughput got=%0d expected=5", run); end
        drain("bp");
        en = 1'b0;
    endtask

    task automatic test_disable_in_flight;
        automatic int rd_seen = 0;
        automatic int pops = 0;
        out_ready = 1'b1;
        write_bytes(8'hC0, 3);
        en = 1'b1;
        @(negedge clock);
        checks++;
        if (fifo_rd !== 1'b1) begin failures++; $display("FAIL dis_first_rd got=%b expected=1", fifo_rd); end
        @(posedge clock); #1;
        en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (fifo_rd) rd_seen++;
            if (out_valid && out_ready) pops++;
            @(posedge clock); #1;
        end
        checks += 2;
        if (rd_seen !== 0) begin failures++; $display("FAIL dis_no_rd got=%0d expected=0", rd_seen); end
        if (pops !== 1) begin failures++; $display("FAIL dis_delivered got=%0d expected=1", pops); end
        en = 1'b1;
        drain("dis");
        en = 1'b0;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        write_bytes(8'hD0, 3);
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_count === 16'd0) begin
            failures++; $display("FAIL areset_pre got=%b/%0d expected=1/nonzero", out_valid, out_count);
        end
        @(posedge clock); #3;
        rst = 1'b1;
        #1;
        checks += 5;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL areset_valid got=%b expected=0", out_valid); end
        if (fifo_rd !== 1'b0)    begin failures++; $display("FAIL areset_rd got=%b expected=0", fifo_rd); end
        if (out_count !== 16'd0) begin failures++; $display("FAIL areset_count got=%0d expected=0", out_count); end
        if (out_count4 !== 4'd0) begin failures++; $display("FAIL areset_count4 got=%0d expected=0", out_count4); end
        if (out_data !== 8'h00)  begin failures++; $display("FAIL areset_data got=%02h expected=00", out_data); end
        exp_q.delete();
        exp_q.push_back(8'hD2);
        @(posedge clock); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drain("areset");
        checks++;
        if (out_count !== 16'd1) begin failures++; $display("FAIL areset_after got=%0d expected=1", out_count); end
        en = 1'b0;
    endtask

    task automatic test_counter_wrap;
        #2 rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        write_bytes(8'hE0, 17);
        en = 1'b1;
        drain("wrap");
        checks += 2;
        if (out_count !== 16'd17) begin failures++; $display("FAIL wrap_count16 got=%0d expected=17", out_count); end
        if (out_count4 !== 4'd1)  begin failures++; $display("FAIL wrap_count4 got=%0d expected=1", out_count4); end
        en = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_burst();
        test_write_collision();
        test_backpressure();
        test_disable_in_flight();
        test_async_reset();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
